pipeline_hazard_ctrl: RTL and testbench

- Central stall/flush sequencer for the 5-stage pipeline (IF, OF, EX, MA, RW).
- Watches the instructions held in the OF and EX stages and drives per-latch load-enable and bubble controls for the PC, IF_OF and OF_EX latches, plus the branch PC select.
- Handles three cases: load-use stalls, multi-cycle mul/div/mod occupancy of EX, and taken-branch flushes.
- Keeps saturating stall/flush event counters for performance debug.

---
 rtl/pipeline_hazard_ctrl_if.sv | 34 +++
 rtl/pipeline_hazard_ctrl.sv | 168 ++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_ctrl_if.sv
// Control bus between the hazard sequencer and the pipeline datapath.
// The master side (datapath) presents the OF/EX instructions and branch
// resolution; the slave side (sequencer) returns latch controls and counters.
interface pipeline_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [31:0]      of_ir;
    logic [31:0]      ex_ir;
    logic             ex_branch_taken;
    logic             pc_write_en;
    logic             if_of_en;
    logic             of_ex_en;
    logic             if_of_bubble;
    logic             of_ex_bubble;
    logic             ex_ma_bubble;
    logic             pc_sel_branch;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic [1:0]       state_dbg;

    modport master (
        output of_ir, ex_ir, ex_branch_taken,
        input  pc_write_en, if_of_en, of_ex_en,
        input  if_of_bubble, of_ex_bubble, ex_ma_bubble, pc_sel_branch,
        input  stall_cnt, flush_cnt, state_dbg
    );

    modport slave (
        input  of_ir, ex_ir, ex_branch_taken,
        output pc_write_en, if_of_en, of_ex_en,
        output if_of_bubble, of_ex_bubble, ex_ma_bubble, pc_sel_branch,
        output stall_cnt, flush_cnt, state_dbg
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use stalls,
// multi-cycle mul/div/mod occupancy of EX, and taken-branch flushes,
// with saturating stall/flush event counters.
module pipeline_hazard_ctrl #(
    parameter int          MD_LAT = 4,
    parameter logic [31:0] NOP_IR = 32'h68000000,
    parameter int          CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    pipeline_hazard_ctrl_if.slave    bus
);
    typedef enum logic [1:0] {
        S_RUN     = 2'd0,
        S_MD_WAIT = 2'd1
    } state_t;

    // The nop opcode is taken from the bubble instruction itself so both agree.
    localparam logic [4:0] OP_NOP  = NOP_IR[31:27];
    localparam logic [4:0] OP_LD   = 5'b01110;
    localparam logic [4:0] OP_ST   = 5'b01111;
    localparam logic [4:0] OP_MUL  = 5'b00010;
    localparam logic [4:0] OP_DIV  = 5'b00011;
    localparam logic [4:0] OP_MOD  = 5'b00100;
    localparam logic [4:0] OP_RET  = 5'b10100;
    localparam logic [4:0] OP_B    = 5'b10010;
    localparam logic [4:0] OP_BEQ  = 5'b10000;
    localparam logic [4:0] OP_BGT  = 5'b10001;
    localparam logic [4:0] OP_CALL = 5'b10011;
    localparam logic [4:0] OP_MOV  = 5'b01001;
    localparam logic [4:0] OP_NOT  = 5'b01000;
    localparam logic [3:0] MD_LOAD = 4'(MD_LAT - 2);

    state_t           r_state;
    state_t           w_state_next;
    logic [3:0]       r_md_cnt;
    logic [3:0]       w_md_cnt_next;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;
    logic             w_stall_inc;
    logic             w_flush_inc;

    logic [4:0] w_of_op;
    logic       w_of_i;
    logic [3:0] w_of_rd;
    logic [3:0] w_of_rs1;
    logic [3:0] w_of_rs2;
    logic [4:0] w_ex_op;
    logic [3:0] w_ex_rd;
    logic       w_of_no_src;
    logic       w_rs1_read;
    logic       w_rs2_read;
    logic       w_lu;
    logic       w_md_in_ex;

    assign w_of_op  = bus.of_ir[31:27];
    assign w_of_i   = bus.of_ir[26];
    assign w_of_rd  = bus.of_ir[25:22];
    assign w_of_rs1 = bus.of_ir[21:18];
    assign w_of_rs2 = bus.of_ir[17:14];
    assign w_ex_op  = bus.ex_ir[31:27];
    assign w_ex_rd  = bus.ex_ir[25:22];

    // Decode which registers the OF instruction reads and detect hazards against EX.
    always_comb begin
        w_of_no_src = (w_of_op == OP_NOP) || (w_of_op == OP_B)   || (w_of_op == OP_BEQ) ||
                      (w_of_op == OP_BGT) || (w_of_op == OP_CALL) || (w_of_op == OP_RET) ||
                      (w_of_op == OP_MOV) || (w_of_op == OP_NOT);
        w_rs1_read  = !w_of_no_src;
        w_rs2_read  = !w_of_i && !w_of_no_src && (w_of_op != OP_LD) && (w_of_op != OP_ST);
        w_lu        = (w_ex_op == OP_LD) &&
                      ((w_rs1_read && (w_of_rs1 == w_ex_rd)) ||
                       (w_rs2_read && (w_of_rs2 == w_ex_rd)) ||
                       ((w_of_op == OP_ST)  && (w_of_rd == w_ex_rd)) ||
                       ((w_of_op == OP_RET) && (w_ex_rd == 4'd15)));
        w_md_in_ex  = (w_ex_op == OP_MUL) || (w_ex_op == OP_DIV) || (w_ex_op == OP_MOD);
    end

    // State and md occupancy counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_RUN;
            r_md_cnt <= 4'd0;
        end else begin
            r_state  <= w_state_next;
            r_md_cnt <= w_md_cnt_next;
        end
    end

    // Next state, md countdown and event-counter increments.
    always_comb begin
        w_state_next  = r_state;
        w_md_cnt_next = r_md_cnt;
        w_stall_inc   = 1'b0;
        w_flush_inc   = 1'b0;
        case (r_state)
            S_RUN: begin
                if (w_md_in_ex) begin
                    w_state_next  = S_MD_WAIT;
                    w_md_cnt_next = MD_LOAD;
                    w_stall_inc   = 1'b1;
                end else if (bus.ex_branch_taken) begin
                    w_flush_inc   = 1'b1;
                end else if (w_lu) begin
                    w_stall_inc   = 1'b1;
                end
            end
            S_MD_WAIT: begin
                // EX is still busy with the md op, so branches and load-use are moot here.
                if (r_md_cnt != 4'd0) begin
                    w_md_cnt_next = r_md_cnt - 4'd1;
                    w_stall_inc   = 1'b1;
                end else begin
                    w_state_next  = S_RUN;
                end
            end
            default: w_state_next = S_RUN;
        endcase
    end

    // Saturating performance counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall_inc && (r_stall_cnt != {CNT_W{1'b1}}))
                r_stall_cnt <= r_stall_cnt + 1'b1;
            if (w_flush_inc && (r_flush_cnt != {CNT_W{1'b1}}))
                r_flush_cnt <= r_flush_cnt + 1'b1;
        end
    end

    // Latch controls; forced quiet while reset is held so nothing loads.
    always_comb begin
        bus.pc_write_en   = 1'b0;
        bus.if_of_en      = 1'b0;
        bus.of_ex_en      = 1'b0;
        bus.if_of_bubble  = 1'b0;
        bus.of_ex_bubble  = 1'b0;
        bus.ex_ma_bubble  = 1'b0;
        bus.pc_sel_branch = 1'b0;
        if (!reset) begin
            if ((r_state == S_RUN && w_md_in_ex) ||
                (r_state == S_MD_WAIT && r_md_cnt != 4'd0)) begin
                bus.ex_ma_bubble  = 1'b1;
            end else if (r_state == S_RUN && bus.ex_branch_taken) begin
                bus.pc_write_en   = 1'b1;
                bus.if_of_en      = 1'b1;
                bus.of_ex_en      = 1'b1;
                bus.if_of_bubble  = 1'b1;
                bus.of_ex_bubble  = 1'b1;
                bus.pc_sel_branch = 1'b1;
            end else if (r_state == S_RUN && w_lu) begin
                bus.of_ex_en      = 1'b1;
                bus.of_ex_bubble  = 1'b1;
            end else begin
                bus.pc_write_en   = 1'b1;
                bus.if_of_en      = 1'b1;
                bus.of_ex_en      = 1'b1;
            end
        end
    end

    assign bus.stall_cnt = r_stall_cnt;
    assign bus.flush_cnt = r_flush_cnt;
    assign bus.state_dbg = r_state;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl (CNT_W overridden to 4 so that
// saturation is reachable). Inputs change 1 ns after posedge, outputs are
// checked on negedge.
module tb_pipeline_hazard_ctrl;
    localparam int          CNT_W  = 4;
    localparam int          MD_LAT = 4;
    localparam logic [31:0] NOP    = 32'h68000000;

    localparam logic [4:0] OP_ADD = 5'b00000;
    localparam logic [4:0] OP_LD  = 5'b01110;
    localparam logic [4:0] OP_ST  = 5'b01111;
    localparam logic [4:0] OP_MUL = 5'b00010;
    localparam logic [4:0] OP_BEQ = 5'b10000;
    localparam logic [4:0] OP_RET = 5'b10100;

    // Control vector order: pc_we, if_of_en, of_ex_en, if_of_bub, of_ex_bub, ex_ma_bub, pc_sel
    localparam logic [6:0] C_RST   = 7'b0000000;
    localparam logic [6:0] C_RUN   = 7'b1110000;
    localparam logic [6:0] C_LU    = 7'b0010100;
    localparam logic [6:0] C_MD    = 7'b0000010;
    localparam logic [6:0] C_FLUSH = 7'b1111101;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;

    pipeline_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

    pipeline_hazard_ctrl #(.MD_LAT(MD_LAT), .NOP_IR(NOP), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [6:0] ctl;
    assign ctl = {bus.pc_write_en, bus.if_of_en, bus.of_ex_en, bus.if_of_bubble,
                  bus.of_ex_bubble, bus.ex_ma_bubble, bus.pc_sel_branch};

    function automatic logic [31:0] enc(input logic [4:0] op, input logic i,
                                        input logic [3:0] rd, input logic [3:0] rs1,
                                        input logic [3:0] rs2);
        return {op, i, rd, rs1, rs2, 14'd0};
    endfunction

    // Present one cycle of inputs and wait for the sampling point.
    task automatic step(input logic [31:0] of_v, input logic [31:0] ex_v, input logic br);
        @(posedge clk);
        #1;
        bus.of_ir = of_v;
        bus.ex_ir = ex_v;
        bus.ex_branch_taken = br;
        @(negedge clk);
    endtask

    task automatic do_reset;
        bus.of_ir = NOP;
        bus.ex_ir = NOP;
        bus.ex_branch_taken = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset;
        bus.of_ir = NOP;
        bus.ex_ir = NOP;
        bus.ex_branch_taken = 1'b0;
        @(negedge clk);
        n_checks++;
        if (ctl !== C_RST || bus.state_dbg !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_hold: ctl=%b state=%0d, required ctl=%b state=0", ctl, bus.state_dbg, C_RST);
        end
        #1;
        reset = 1'b0;
        #1;
        n_checks++;
        if (ctl !== C_RUN || bus.state_dbg !== 2'd0 || bus.stall_cnt !== 4'd0 || bus.flush_cnt !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_release: ctl=%b state=%0d stall=%0d flush=%0d, required ctl=%b state=0 cnts=0",
                     ctl, bus.state_dbg, bus.stall_cnt, bus.flush_cnt, C_RUN);
        end
        $display("test_reset: ctl=%b state=%0d", ctl, bus.state_dbg);
    endtask

    task automatic test_load_use;
        logic [31:0] ld_r3;
        ld_r3 = enc(OP_LD, 1'b1, 4'd3, 4'd1, 4'd0);
        do_reset();
        step(enc(OP_ADD, 1'b0, 4'd5, 4'd3, 4'd4), ld_r3, 1'b0);
        n_checks++;
        if (ctl !== C_LU) begin
            n_fail++;
            $display("FAIL lu_stall: ctl=%b, required %b", ctl, C_LU);
        end
        step(enc(OP_ADD, 1'b0, 4'd5, 4'd3, 4'd4), NOP, 1'b0);
        n_checks++;
        if (ctl !== C_RUN || bus.stall_cnt !== 4'd1) begin
            n_fail++;
            $display("FAIL lu_after: ctl=%b stall=%0d, required ctl=%b stall=1", ctl, bus.stall_cnt, C_RUN);
        end
        step(enc(OP_ADD, 1'b1, 4'd5, 4'd6, 4'd3), ld_r3, 1'b0);
        n_checks++;
        if (ctl !== C_RUN) begin
            n_fail++;
            $display("FAIL lu_imm_nostall: ctl=%b, required %b", ctl, C_RUN);
        end
        step(NOP, NOP, 1'b0);
        n_checks++;
        if (bus.stall_cnt !== 4'd1) begin
            n_fail++;
            $display("FAIL lu_imm_cnt: stall=%0d, required 1", bus.stall_cnt);
        end
        $display("test_load_use: stall_cnt=%0d", bus.stall_cnt);
    endtask

    task automatic test_md;
        logic [6:0] exp_ctl [5];
        logic [1:0] exp_st  [5];
        logic [31:0] mul_ir;
        mul_ir = enc(OP_MUL, 1'b0, 4'd2, 4'd3, 4'd4);
        exp_ctl = '{C_MD, C_MD, C_MD, C_RUN, C_RUN};
        exp_st  = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd0};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(NOP, (i < 4) ? mul_ir : NOP, 1'b0);
            n_checks++;
            if (ctl !== exp_ctl[i] || bus.state_dbg !== exp_st[i]) begin
                n_fail++;
                $display("FAIL md_cycle%0d: ctl=%b state=%0d, required ctl=%b state=%0d",
                         i, ctl, bus.state_dbg, exp_ctl[i], exp_st[i]);
            end
        end
        n_checks++;
        if (bus.stall_cnt !== 4'd3) begin
            n_fail++;
            $display("FAIL md_stall_cnt: stall=%0d, required 3", bus.stall_cnt);
        end
        $display("test_md: stall_cnt=%0d", bus.stall_cnt);
    endtask

    task automatic test_branch;
        logic [31:0] beq_ir;
        beq_ir = enc(OP_BEQ, 1'b0, 4'd0, 4'd0, 4'd0);
        do_reset();
        for (int p = 0; p < 3; p++) begin
            step(NOP, beq_ir, 1'b1);
            n_checks++;
            if (ctl !== C_FLUSH) begin
                n_fail++;
                $display("FAIL branch_flush%0d: ctl=%b, required %b", p, ctl, C_FLUSH);
            end
            step(NOP, NOP, 1'b0);
            n_checks++;
            if (bus.flush_cnt !== 4'(p + 1) || ctl !== C_RUN) begin
                n_fail++;
                $display("FAIL branch_cnt%0d: flush=%0d ctl=%b, required flush=%0d ctl=%b",
                         p, bus.flush_cnt, ctl, p + 1, C_RUN);
            end
        end
        $display("test_branch: flush_cnt=%0d", bus.flush_cnt);
    endtask

    task automatic test_ret;
        logic [31:0] ret_ir;
        ret_ir = enc(OP_RET, 1'b0, 4'd0, 4'd0, 4'd0);
        do_reset();
        step(ret_ir, enc(OP_ST, 1'b1, 4'd15, 4'd1, 4'd0), 1'b0);
        n_checks++;
        if (ctl !== C_RUN) begin
            n_fail++;
            $display("FAIL ret_st_nostall: ctl=%b, required %b", ctl, C_RUN);
        end
        step(ret_ir, enc(OP_LD, 1'b1, 4'd15, 4'd1, 4'd0), 1'b0);
        n_checks++;
        if (ctl !== C_LU) begin
            n_fail++;
            $display("FAIL ret_ld_stall: ctl=%b, required %b", ctl, C_LU);
        end
        step(ret_ir, NOP, 1'b0);
        n_checks++;
        if (ctl !== C_RUN || bus.stall_cnt !== 4'd1) begin
            n_fail++;
            $display("FAIL ret_after: ctl=%b stall=%0d, required ctl=%b stall=1", ctl, bus.stall_cnt, C_RUN);
        end
        $display("test_ret: stall_cnt=%0d", bus.stall_cnt);
    endtask

    task automatic test_reset_mid_md;
        logic [31:0] mul_ir;
        mul_ir = enc(OP_MUL, 1'b0, 4'd2, 4'd3, 4'd4);
        do_reset();
        step(NOP, mul_ir, 1'b0);
        step(NOP, mul_ir, 1'b0);
        n_checks++;
        if (bus.state_dbg !== 2'd1 || ctl !== C_MD) begin
            n_fail++;
            $display("FAIL midmd_pre: state=%0d ctl=%b, required state=1 ctl=%b", bus.state_dbg, ctl, C_MD);
        end
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if (ctl !== C_RST || bus.state_dbg !== 2'd0 || bus.stall_cnt !== 4'd0) begin
            n_fail++;
            $display("FAIL midmd_async: ctl=%b state=%0d stall=%0d, required ctl=%b state=0 stall=0",
                     ctl, bus.state_dbg, bus.stall_cnt, C_RST);
        end
        bus.ex_ir = NOP;
        @(negedge clk);
        #1;
        reset = 1'b0;
        step(NOP, NOP, 1'b0);
        n_checks++;
        if (ctl !== C_RUN || bus.state_dbg !== 2'd0 || bus.stall_cnt !== 4'd0) begin
            n_fail++;
            $display("FAIL midmd_after: ctl=%b state=%0d stall=%0d, required ctl=%b state=0 stall=0",
                     ctl, bus.state_dbg, bus.stall_cnt, C_RUN);
        end
        $display("test_reset_mid_md: state=%0d", bus.state_dbg);
    endtask

    task automatic test_saturation;
        logic [31:0] ld_r3;
        logic [31:0] add_r3;
        int exp_cnt;
        ld_r3  = enc(OP_LD, 1'b1, 4'd3, 4'd1, 4'd0);
        add_r3 = enc(OP_ADD, 1'b0, 4'd5, 4'd3, 4'd4);
        do_reset();
        // Holding the ld in EX retriggers the load-use stall every cycle.
        for (int i = 0; i < 20; i++) begin
            step(add_r3, ld_r3, 1'b0);
            exp_cnt = (i < 15) ? i : 15;
            n_checks++;
            if (bus.stall_cnt !== 4'(exp_cnt)) begin
                n_fail++;
                $display("FAIL sat_cycle%0d: stall=%0d, required %0d", i, bus.stall_cnt, exp_cnt);
            end
        end
        step(NOP, NOP, 1'b0);
        n_checks++;
        if (bus.stall_cnt !== 4'hF) begin
            n_fail++;
            $display("FAIL sat_final: stall=%0d, required 15", bus.stall_cnt);
        end
        $display("test_saturation: stall_cnt=%0d", bus.stall_cnt);
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_md();
        test_branch();
        test_ret();
        test_reset_mid_md();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
